// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu block: FSM states, opcode values and
// instruction-word field positions.
package cpu_pkg;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam int OP_LSB = 9;
    localparam int RX_LSB = 6;
    localparam int RY_LSB = 3;
    localparam int RZ_LSB = 0;

    function automatic logic [2:0] ir_field(input logic [15:0] ir, input int lsb);
        return ir[lsb +: 3];
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result = a op b, modulo 2^16, no flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  op,
    output logic [15:0] result
);

    always_comb begin
        result = b;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit processor: eight registers, A/G ALU latches and one
// shared bus driven by a priority mux of one-hot selects.
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    output logic [15:0] Bus,
    output logic        Done
);

    state_t      state, state_nxt;
    logic [15:0] regs [8];
    logic [15:0] ir, a_reg, g_reg, alu_out;
    logic [2:0]  op, rx, ry, rz;
    logic        sel_din, sel_g;
    logic [7:0]  sel_r;
    logic        ir_load, a_load, g_load, rx_load;

    assign op = ir_field(ir, OP_LSB);
    assign rx = ir_field(ir, RX_LSB);
    assign ry = ir_field(ir, RY_LSB);
    assign rz = ir_field(ir, RZ_LSB);

    cpu_alu u_alu (
        .a      (a_reg),
        .b      (Bus),
        .op     (op),
        .result (alu_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_din   = 1'b0;
        sel_g     = 1'b0;
        sel_r     = '0;
        ir_load   = 1'b0;
        a_load    = 1'b0;
        g_load    = 1'b0;
        rx_load   = 1'b0;
        Done      = 1'b0;
        case (state)
            T0: begin
                if (run) begin
                    ir_load   = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        sel_r[ry] = 1'b1;
                        rx_load   = 1'b1;
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_MVI: begin
                        sel_din   = 1'b1;
                        rx_load   = 1'b1;
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_NOP: begin
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                    default: begin
                        sel_r[ry] = 1'b1;
                        a_load    = 1'b1;
                        state_nxt = T2;
                    end
                endcase
            end
            T2: begin
                sel_r[rz] = 1'b1;
                g_load    = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                sel_g     = 1'b1;
                rx_load   = 1'b1;
                Done      = 1'b1;
                state_nxt = T0;
            end
            default: state_nxt = T0;
        endcase
    end

    // Later assignments win: din over R0 over R1 .. R7 over G over zero.
    always_comb begin
        Bus = '0;
        if (sel_g) Bus = g_reg;
        for (int i = 7; i >= 0; i--) begin
            if (sel_r[i]) Bus = regs[i];
        end
        if (sel_din) Bus = din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (ir_load) ir <= din;
            if (a_load)  a_reg <= Bus;
            if (g_load)  g_reg <= alu_out;
            if (rx_load) regs[rx] <= Bus;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed test-plan sequences plus random
// instruction streams checked cycle by cycle against a register-array model.
module tb_cpu;

    localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, NOP = 3'd7;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic [15:0] bus;
    logic        done;

    logic [15:0] rm [8];
    int vectors = 0;
    int errors  = 0;

    cpu dut (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .din    (din),
        .Bus    (bus),
        .Done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] y, input logic [15:0] z);
        case (op)
            ADD:     return y + z;
            SUB:     return y - z;
            AND_:    return y & z;
            OR_:     return y | z;
            default: return y ^ z;
        endcase
    endfunction

    // Called at a falling edge with the DUT in T0; returns at a falling edge in T0.
    task automatic exec(input logic [3:0] hi, input logic [2:0] op, input logic [2:0] rx,
                        input logic [2:0] ry, input logic [2:0] rz, input logic [15:0] imm);
        logic [15:0] y, z, res;
        y   = rm[ry];
        z   = rm[rz];
        run = 1'b1;
        din = {hi, op, rx, ry, rz};
        #1;
        check("t0_bus", bus, 16'h0000);
        check("t0_done", 16'(done), 16'h0000);
        @(negedge clk);
        din = imm;
        #1;
        case (op)
            MV: begin
                check("mv_bus", bus, y);
                check("mv_done", 16'(done), 16'h0001);
                rm[rx] = y;
            end
            MVI: begin
                check("mvi_bus", bus, imm);
                check("mvi_done", 16'(done), 16'h0001);
                rm[rx] = imm;
            end
            NOP: begin
                check("nop_bus", bus, 16'h0000);
                check("nop_done", 16'(done), 16'h0001);
            end
            default: begin
                check("alu_t1_bus", bus, y);
                check("alu_t1_done", 16'(done), 16'h0000);
                @(negedge clk);
                din = 16'($urandom);
                #1;
                check("alu_t2_bus", bus, z);
                check("alu_t2_done", 16'(done), 16'h0000);
                @(negedge clk);
                #1;
                res = ref_op(op, y, z);
                check("alu_t3_bus", bus, res);
                check("alu_t3_done", 16'(done), 16'h0001);
                rm[rx] = res;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic peek_all();
        for (int i = 0; i < 8; i++) exec(4'h0, MV, 3'(i), 3'(i), 3'(i), 16'(i));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rm[i] = '0;
        resetn = 1'b0;
        run    = 1'b1;
        din    = 16'hA5A5;
        #1;
        check("rst_bus", bus, 16'h0000);
        check("rst_done", 16'(done), 16'h0000);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_hold_bus", bus, 16'h0000);
            check("rst_hold_done", 16'(done), 16'h0000);
        end
        @(negedge clk);
        resetn = 1'b1;
        peek_all();

        // Directed sequences from the test plan
        exec(4'b0001, MVI, 3'd0, 3'd6, 3'd4, 16'h56B8);
        exec(4'h0, MVI, 3'd1, 3'd0, 3'd0, 16'h0005);
        exec(4'h0, MV,  3'd2, 3'd1, 3'd0, 16'h1234);
        exec(4'h0, MVI, 3'd2, 3'd0, 3'd0, 16'h0003);
        exec(4'h0, ADD, 3'd3, 3'd1, 3'd2, 16'h0000);
        exec(4'h0, SUB, 3'd4, 3'd2, 3'd1, 16'h0000);
        exec(4'h0, MVI, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        exec(4'h0, ADD, 3'd1, 3'd1, 3'd1, 16'h0000);
        exec(4'h0, MVI, 3'd5, 3'd0, 3'd0, 16'hF0F0);
        exec(4'h0, MVI, 3'd6, 3'd0, 3'd0, 16'h0FF0);
        exec(4'h0, AND_, 3'd7, 3'd5, 3'd6, 16'h0000);
        exec(4'h0, OR_,  3'd7, 3'd5, 3'd6, 16'h0000);
        exec(4'hF, XOR_, 3'd7, 3'd5, 3'd6, 16'h0000);
        exec(4'h0, NOP, 3'd3, 3'd1, 3'd2, 16'hBEEF);
        peek_all();

        // Idle with run low
        run = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("idle_bus", bus, 16'h0000);
            check("idle_done", 16'(done), 16'h0000);
        end
        @(negedge clk);
        exec(4'h0, MV, 3'd0, 3'd3, 3'd0, 16'h0000);

        // Reset in T2 of an add: nothing written, back to T0
        din = {4'h0, ADD, 3'd5, 3'd3, 3'd4};
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("abort_bus", bus, 16'h0000);
        check("abort_done", 16'(done), 16'h0000);
        for (int i = 0; i < 8; i++) rm[i] = '0;
        @(negedge clk);
        resetn = 1'b1;
        peek_all();

        // Random streams
        for (int i = 0; i < 8; i++) exec(4'h0, MVI, 3'(i), 3'd0, 3'd0, 16'($urandom));
        for (int n = 0; n < 150; n++) begin
            exec(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), 16'($urandom));
        end
        peek_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
